// File: rtl/ro_puf_pkg.sv
// ============================================================================
// Module  : ro_puf_pkg
// Brief   : Shared types, default widths and timing helper for the RO-PUF
//           measurement sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ro_puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_DONE   = 3'd5
  } ro_puf_state_t;

  localparam int RO_SEL_W = 4;
  localparam int RO_CNT_W = 8;

  // One response bit costs CLEAR + window + settle + SAMPLE cycles.
  function automatic int ro_puf_period(input int window, input int settle);
    return window + settle + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ro_puf_win_timer.sv
// ============================================================================
// Module  : ro_puf_win_timer
// Brief   : Loadable down-counter; done is high while the count is zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_puf_win_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/ro_puf_ctrl.sv
// ============================================================================
// Module  : ro_puf_ctrl
// Brief   : Cycle-counted RO-PUF measurement sequencer (clear/run/settle/sample
//           per response bit, then a valid/ready response handshake).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_puf_ctrl
  import ro_puf_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int SEL_W  = RO_SEL_W,
  parameter int CNT_W  = RO_CNT_W,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  challenge,
  input  logic [CNT_W-1:0]  count1,
  input  logic [CNT_W-1:0]  count2,
  input  logic              resp_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              cnt_clr,
  output logic              ro_en,
  output logic              busy,
  output logic [N_BITS-1:0] resp,
  output logic              resp_valid
);

  localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [TW-1:0] WIN_LOAD = TW'(WINDOW - 1);
  localparam logic [TW-1:0] SET_LOAD = TW'(SETTLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BITS - 1);

  ro_puf_state_t state, next_state;
  logic [IW-1:0] idx;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          abort_hit;

  assign abort_hit = abort && (state != S_IDLE);

  ro_puf_win_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // The timer is loaded on the edge entering RUN/SETTLE so its first
  // in-state value is LOAD, giving exactly LOAD+1 cycles before done.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = WIN_LOAD;
    unique case (state)
      S_IDLE:   if (start) next_state = S_CLEAR;
      S_CLEAR: begin
        next_state = S_RUN;
        tmr_load   = 1'b1;
      end
      S_RUN: if (tmr_done) begin
        next_state = S_SETTLE;
        tmr_load   = 1'b1;
        tmr_val    = SET_LOAD;
      end
      S_SETTLE: if (tmr_done) next_state = S_SAMPLE;
      S_SAMPLE: next_state = (idx == LAST_IDX) ? S_DONE : S_CLEAR;
      S_DONE:   if (resp_ready) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort_hit) next_state = S_IDLE;
  end

  // Outputs are decoded from next_state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel        <= '0;
      cnt_clr    <= 1'b0;
      ro_en      <= 1'b0;
      busy       <= 1'b0;
      resp       <= '0;
      resp_valid <= 1'b0;
      idx        <= '0;
    end else begin
      cnt_clr    <= (next_state == S_CLEAR);
      ro_en      <= (next_state == S_RUN);
      busy       <= (next_state != S_IDLE);
      resp_valid <= (next_state == S_DONE);
      if (abort_hit) begin
        resp <= '0;
        idx  <= '0;
      end else begin
        unique case (state)
          S_IDLE: if (start) begin
            resp <= '0;
            idx  <= '0;
            sel  <= challenge;
          end
          S_SAMPLE: begin
            resp[idx] <= (count1 > count2);
            if (idx != LAST_IDX) begin
              idx <= idx + IW'(1);
              sel <= sel + SEL_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ro_puf_ctrl.sv
// ============================================================================
// Module  : tb_ro_puf_ctrl
// Brief   : Self-checking bench for ro_puf_ctrl (two instances: 4-bit and
//           2-bit select) against an elapsed-cycle schedule model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ro_puf_ctrl;
  import ro_puf_pkg::*;

  localparam int NB = 4;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int P  = 12;  // W + S + 2 by hand

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start, abort, resp_ready;
  logic [3:0] challenge;

  logic [7:0] c1a, c2a, c1b, c2b;
  logic [3:0] sel_a, resp_a;
  logic [1:0] sel_b;
  logic [3:0] resp_b;
  logic clr_a, en_a, busy_a, rv_a;
  logic clr_b, en_b, busy_b, rv_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_edge = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Pair responders: the count values depend only on the selected pair.
  function automatic logic [7:0] c1a_of(input logic [3:0] s);
    return s[0] ? 8'd5 : 8'd10;
  endfunction
  function automatic logic [7:0] c2a_of(input logic [3:0] s);
    return s[0] ? 8'd10 : 8'd5;
  endfunction
  function automatic logic [7:0] c1b_of(input logic [1:0] s);
    case (s)
      2'd0:    return 8'd0;
      2'd1:    return 8'd9;
      2'd2:    return 8'd255;
      default: return 8'd7;
    endcase
  endfunction
  function automatic logic [7:0] c2b_of(input logic [1:0] s);
    case (s)
      2'd0:    return 8'd1;
      2'd1:    return 8'd2;
      2'd2:    return 8'd0;
      default: return 8'd7;
    endcase
  endfunction

  assign c1a = c1a_of(sel_a);
  assign c2a = c2a_of(sel_a);
  assign c1b = c1b_of(sel_b);
  assign c2b = c2b_of(sel_b);

  ro_puf_ctrl #(.N_BITS(NB), .SEL_W(4), .CNT_W(8), .WINDOW(W), .SETTLE(S)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .challenge(challenge),
    .count1(c1a), .count2(c2a), .resp_ready(resp_ready),
    .sel(sel_a), .cnt_clr(clr_a), .ro_en(en_a), .busy(busy_a),
    .resp(resp_a), .resp_valid(rv_a)
  );

  ro_puf_ctrl #(.N_BITS(NB), .SEL_W(2), .CNT_W(8), .WINDOW(W), .SETTLE(S)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .challenge(challenge[1:0]),
    .count1(c1b), .count2(c2b), .resp_ready(resp_ready),
    .sel(sel_b), .cnt_clr(clr_b), .ro_en(en_b), .busy(busy_b),
    .resp(resp_b), .resp_valid(rv_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a measurement is just "m_e edges since accept"; everything else
  // follows from where m_e falls in the N_BITS x P schedule.
  bit         m_busy = 1'b0;
  int         m_e = 0;
  logic [3:0] m_chal = '0;
  logic [3:0] m_sel = '0;
  logic [3:0] m_resp_a = '0;
  logic [3:0] m_resp_b = '0;

  initial forever begin
    int j;
    logic [3:0] pa;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 1'b0; m_e = 0; m_chal = '0; m_sel = '0;
      m_resp_a = '0; m_resp_b = '0;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_e = 0; m_chal = challenge;
          m_resp_a = '0; m_resp_b = '0; acc_edge = cyc;
        end
      end else if (abort) begin
        m_busy = 1'b0; m_resp_a = '0; m_resp_b = '0;
      end else if (m_e == NB * P) begin
        if (resp_ready) m_busy = 1'b0;
      end else begin
        m_e++;
        if (m_e % P == 0) begin
          j  = m_e / P - 1;
          pa = m_chal + 4'(j);
          m_resp_a[j] = c1a_of(pa) > c2a_of(pa);
          m_resp_b[j] = c1b_of(pa[1:0]) > c2b_of(pa[1:0]);
        end
      end
      if (m_busy) m_sel = m_chal + 4'((m_e >= NB * P) ? NB - 1 : m_e / P);
    end
  end

  initial forever begin
    bit dn, e_clr, e_en;
    int ph;
    @(negedge clk);
    if (chk_en && !rst) begin
      dn    = m_busy && (m_e == NB * P);
      ph    = m_e % P;
      e_clr = m_busy && !dn && (ph == 0);
      e_en  = m_busy && !dn && (ph >= 1) && (ph <= W);
      chk("a_sel", sel_a, m_sel);
      chk("a_cnt_clr", clr_a, e_clr);
      chk("a_ro_en", en_a, e_en);
      chk("a_busy", busy_a, m_busy);
      chk("a_resp", resp_a, m_resp_a);
      chk("a_resp_valid", rv_a, dn);
      chk("b_sel", sel_b, m_sel[1:0]);
      chk("b_cnt_clr", clr_b, e_clr);
      chk("b_ro_en", en_b, e_en);
      chk("b_busy", busy_b, m_busy);
      chk("b_resp", resp_b, m_resp_b);
      chk("b_resp_valid", rv_b, dn);
    end
  end

  logic [3:0] qa[$];
  logic [1:0] qb[$];
  int runs[$];
  int run = 0;
  bit rv_seen = 1'b0;

  initial forever begin
    @(negedge clk);
    if (en_a) run++;
    else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
    if (clr_a) begin
      qa.push_back(sel_a);
      qb.push_back(sel_b);
    end
    if (rv_a) rv_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [3:0] c);
    start = 1'b1;
    challenge = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int lat);
    int n = 0;
    while (rv_a !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid_reached"}, rv_a, 1);
    lat = cyc - acc_edge;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  logic [3:0] exp_sa [4] = '{4'd3, 4'd4, 4'd5, 4'd6};
  logic [1:0] exp_sb [4] = '{2'd3, 2'd0, 2'd1, 2'd2};

  initial begin
    int lat;
    start = 1'b0; abort = 1'b0; resp_ready = 1'b0; challenge = '0;
    tick(3);
    chk("rst_sel", sel_a, 0);
    chk("rst_cnt_clr", clr_a, 0);
    chk("rst_ro_en", en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_resp", resp_a, 0);
    chk("rst_resp_valid", rv_a, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(2);

    // Basic run with wrap on the 2-bit instance
    qa.delete(); qb.delete(); runs.delete();
    do_start(4'd3);
    wait_valid("basic", lat);
    chk("basic_latency", lat, 48);
    chk("basic_resp_a", resp_a, 4'b1010);
    chk("basic_resp_b", resp_b, 4'b1100);
    chk("basic_nclr", qa.size(), 4);
    for (int i = 0; i < 4 && i < qa.size(); i++) begin
      chk("basic_sel_seq_a", qa[i], exp_sa[i]);
      chk("basic_sel_seq_b", qb[i], exp_sb[i]);
    end
    chk("window_nruns", runs.size(), 4);
    foreach (runs[i]) chk("window_len", runs[i], W);

    // Handshake stall with an ignored start pulse
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == 10);
      challenge = 4'd5;
    end
    start = 1'b0;
    chk("stall_resp", resp_a, 4'b1010);
    chk("stall_valid", rv_a, 1);
    chk("stall_busy", busy_a, 1);
    start = 1'b1;
    handshake();
    start = 1'b0;
    chk("hs_idle", busy_a, 0);
    chk("hs_valid_drop", rv_a, 0);
    tick(2);

    // Abort in IDLE is a no-op, abort in RUN of bit 2 cancels
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("idle_abort_busy", busy_a, 0);
    rv_seen = 1'b0;
    do_start(4'd3);
    tick(26);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_ro_en", en_a, 0);
    chk("abort_resp", resp_a, 0);
    tick(5);
    chk("abort_no_valid", rv_seen, 0);
    do_start(4'd3);
    wait_valid("post_abort", lat);
    chk("post_abort_latency", lat, 48);
    chk("post_abort_resp", resp_a, 4'b1010);

    // Abort together with resp_ready in DONE drops the response
    abort = 1'b1; resp_ready = 1'b1;
    tick(1);
    abort = 1'b0; resp_ready = 1'b0;
    chk("abort_done_resp", resp_a, 0);
    chk("abort_done_busy", busy_a, 0);
    tick(2);

    // Async reset in SETTLE of bit 1
    do_start(4'd3);
    tick(P + W + 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", sel_a, 0);
    chk("arst_ro_en", en_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_resp", resp_a, 0);
    chk("arst_cnt_clr", clr_a, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    do_start(4'd3);
    wait_valid("post_rst", lat);
    chk("post_rst_latency", lat, 48);
    chk("post_rst_resp", resp_a, 4'b1010);
    handshake();
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
